// File: rtl/mul_sequencer_if.sv
// -----------------------------------------------------------------------------
// mul_sequencer_if
// Request/response bundle between the execute stage and the iterative
// multiply sequencer.
//   start   : request pulse/level from execute (sampled only while idle)
//   op      : 00 MUL, 01 UMULH, 10 SMULH, 11 reserved (treated as MUL)
//   a, b    : multiplicand / multiplier
//   stall_E : freeze PC, IF/ID, ID/EX while high
//   busy    : sequencer is not idle
//   done    : one-cycle completion pulse
//   result  : selected product half, held until the next accepted start
// master = execute stage (requester), slave = sequencer.
// -----------------------------------------------------------------------------
interface mul_sequencer_if #(
    parameter int N = 64
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         stall_E;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, op, a, b,
        input  stall_E, busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output stall_E, busy, done, result
    );
endinterface

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
// Multi-cycle N-bit shift-add multiplier for MUL / UMULH / SMULH in the
// execute stage. One multiplier bit is consumed per cycle; the pipeline is
// stalled from the start cycle through FIX, and the result is presented with
// a one-cycle done pulse in DONE.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : mul_sequencer_if.slave (start/op/a/b in; stall_E/busy/done/result out)
//
// Configuration macro:
//   MUL_SIGNED_EN : when defined, SMULH takes operand magnitudes in PREP and
//                   negates the product in FIX. When undefined, the sign path
//                   is absent and op 10 behaves as UMULH. Timing is identical.
// -----------------------------------------------------------------------------
module mul_sequencer #(
    parameter int N = 64
) (
    input  logic           clk,
    input  logic           reset,
    mul_sequencer_if.slave bus
);
    localparam int CW = $clog2(N);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]     r_state;
    logic [2:0]     w_next;
    logic [1:0]     r_op;
    logic [N-1:0]   r_a;        // multiplicand (magnitude after PREP)
    logic [N-1:0]   r_b;        // multiplier, shifted right each iteration
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_sign;
    logic [N-1:0]   r_result;
    logic           r_done;
    logic           r_busy;

    logic [N:0]     w_sum;      // {carry, upper half} after the conditional add
    logic [2*N-1:0] w_prod;
    logic           w_hi_sel;
    logic           w_is_smulh;

`ifdef MUL_SIGNED_EN
    assign w_is_smulh = (r_op == 2'b10);
`else
    assign w_is_smulh = 1'b0;
`endif

    assign w_sum    = r_b[0] ? ({1'b0, r_acc[2*N-1:N]} + {1'b0, r_a})
                             :  {1'b0, r_acc[2*N-1:N]};
    assign w_prod   = r_sign ? (~r_acc + 1'b1) : r_acc;
    // 01 and 10 take the high half; 00 and reserved 11 take the low half.
    assign w_hi_sel = (r_op == 2'b01) || (r_op == 2'b10);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_PREP;
            S_PREP:  w_next = S_RUN;
            S_RUN:   if (r_cnt == CW'(N-1)) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == S_DONE);
            r_busy  <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op <= bus.op;
                        r_a  <= bus.a;
                        r_b  <= bus.b;
                    end
                end
                S_PREP: begin
                    r_acc <= '0;
                    r_cnt <= '0;
`ifdef MUL_SIGNED_EN
                    r_sign <= w_is_smulh & (r_a[N-1] ^ r_b[N-1]);
                    // -2^(N-1) negates to itself, which read unsigned is the
                    // exact magnitude 2^(N-1).
                    if (w_is_smulh) begin
                        r_a <= r_a[N-1] ? (~r_a + 1'b1) : r_a;
                        r_b <= r_b[N-1] ? (~r_b + 1'b1) : r_b;
                    end
`else
                    r_sign <= 1'b0;
`endif
                end
                S_RUN: begin
                    // Add into upper half, then shift {carry, acc} right by one.
                    r_acc <= {w_sum, r_acc[N-1:1]};
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_result <= w_hi_sel ? w_prod[2*N-1:N] : w_prod[N-1:0];
                end
                default: ;
            endcase
        end
    end

    // Combinational IDLE&start term lets the pipeline freeze in the very
    // cycle the request is presented.
    assign bus.stall_E = ((r_state == S_IDLE) && bus.start) ||
                         (r_state == S_PREP) || (r_state == S_RUN) ||
                         (r_state == S_FIX);
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.result  = r_result;
endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    longint cyc = 0;
    int checks = 0;
    int errors = 0;
    int run = 0;

    typedef struct {
        logic [63:0] res;
        longint      cyc;
    } exp_t;
    exp_t sb[$];

`ifdef MUL_SIGNED_EN
    localparam logic [63:0] EXP_SM1x1   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_SM3x5   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_SM1xM1  = 64'h0;
`else
    localparam logic [63:0] EXP_SM1x1   = 64'h0;
    localparam logic [63:0] EXP_SM3x5   = 64'h4;
    localparam logic [63:0] EXP_SM1xM1  = 64'hFFFF_FFFF_FFFF_FFFE;
`endif

    mul_sequencer_if #(.N(64)) bus();
    mul_sequencer #(.N(64)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+#1; start is sampled on the next edge (k), done is
    // expected at the negedge of cycle k+66 and stall_E high for 67 cycles.
    task automatic issue(input logic [1:0] op_i, input logic [63:0] a_i,
                         input logic [63:0] b_i, input logic [63:0] exp_i);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        e.res = exp_i;
        e.cyc = cyc + 67;
        sb.push_back(e);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((bus.busy || sb.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("completion_timeout", 64'(n >= 200), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.stall_E) run++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", bus.result, e.res);
                    chk("done_latency_cycle", 64'(cyc), 64'(e.cyc));
                    chk("stall_run_len", 64'(run), 64'd67);
                    chk("stall_low_in_done", 64'(bus.stall_E), 64'd0);
                end
            end
            if (!bus.stall_E) run = 0;
        end else begin
            run = 0;
        end
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) tick();
        chk("rst_busy",   64'(bus.busy),    64'd0);
        chk("rst_done",   64'(bus.done),    64'd0);
        chk("rst_stall",  64'(bus.stall_E), 64'd0);
        chk("rst_result", bus.result,       64'd0);
        reset = 1'b1;
        tick();

        issue(2'b00, 64'd7, 64'd6, 64'd42);
        wait_done();
        issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
        wait_done();
        issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_done();
        issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, EXP_SM1x1);
        wait_done();
        issue(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
        wait_done();
        issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, EXP_SM3x5);
        wait_done();
        issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, EXP_SM1xM1);
        wait_done();
        issue(2'b11, 64'd3, 64'd5, 64'd15);
        wait_done();

        // Reset asserted mid-RUN discards the operation.
        issue(2'b00, 64'd123, 64'd456, 64'd56088);
        repeat (20) tick();
        reset = 1'b0;
        sb.delete();
        #1;
        chk("midrst_busy",   64'(bus.busy),    64'd0);
        chk("midrst_done",   64'(bus.done),    64'd0);
        chk("midrst_stall",  64'(bus.stall_E), 64'd0);
        chk("midrst_result", bus.result,       64'd0);
        tick();
        reset = 1'b1;
        tick();
        issue(2'b00, 64'd3, 64'd5, 64'd15);
        wait_done();

        // start re-asserted during RUN and during DONE is ignored.
        issue(2'b00, 64'd9, 64'd11, 64'd99);
        repeat (10) tick();
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 64'd1000;
        bus.b     = 64'd1000;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        chk("reach_done_timeout", 64'(n >= 100), 64'd0);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 64'd2;
        bus.b     = 64'd2;
        tick();
        bus.start = 1'b0;
        chk("idle_after_done", 64'(bus.busy), 64'd0);
        chk("result_held",     bus.result,    64'd99);
        repeat (3) tick();
        chk("done_start_ignored", 64'(bus.busy), 64'd0);
        chk("result_still_held",  bus.result,    64'd99);
        issue(2'b00, 64'd12, 64'd12, 64'd144);
        wait_done();
        repeat (3) tick();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
